// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/shift ops with registered result and flags,
// plus a shift-add unsigned multiply that holds off issue for DATA_WIDTH cycles.
module alu_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            psr_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] result_hi_o,
  output logic [3:0]            apsr_o
);
  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_ADDC = 4'h3, OP_SUBC = 4'h4,
                         OP_NAND = 4'h5, OP_NOR  = 4'h6, OP_XOR  = 4'h7, OP_XNOR = 4'h8,
                         OP_SHL  = 4'h9, OP_SHR  = 4'hA, OP_ASR  = 4'hB, OP_MUL  = 4'hC;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]           mcand_q, mcand_d;
  logic [2*W-1:0]         acc_q, acc_d;
  logic [W-1:0]           res_q, res_d, hi_q, hi_d;
  logic [3:0]             apsr_q, apsr_d;
  logic                   vld_q, vld_d;

  // Single-cycle datapath
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   cin, cin_add, is_sub, is_nop;
  logic [W-1:0]           bop, alu_res;
  logic [W:0]             add_ext, shl_ext, shr_ext, asr_ext;
  logic                   alu_c, alu_v;
  logic [W:0]             mul_sum;

  always_comb begin
    shamt   = b_i[SHAMT_WIDTH-1:0];
    cin     = psr_i[1];
    is_sub  = (op_i == OP_SUB) || (op_i == OP_SUBC);
    bop     = is_sub ? ~b_i : b_i;
    cin_add = (op_i == OP_ADD) ? 1'b0 : (op_i == OP_SUB) ? 1'b1 : cin;
    add_ext = {1'b0, a_i} + {1'b0, bop} + {{W{1'b0}}, cin_add};
    // Extra bit on the shifted-out side captures the last bit lost.
    shl_ext = {1'b0, a_i} << shamt;
    shr_ext = {a_i, 1'b0} >> shamt;
    asr_ext = $unsigned($signed({a_i, 1'b0}) >>> shamt);
    alu_res = a_i;
    alu_c   = cin;
    alu_v   = 1'b0;
    is_nop  = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB, OP_ADDC, OP_SUBC: begin
        alu_res = add_ext[W-1:0];
        alu_c   = add_ext[W];
        alu_v   = (a_i[W-1] == bop[W-1]) && (add_ext[W-1] != a_i[W-1]);
      end
      OP_NAND: alu_res = ~(a_i & b_i);
      OP_NOR:  alu_res = ~(a_i | b_i);
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_XNOR: alu_res = ~(a_i ^ b_i);
      OP_SHL: begin
        alu_res = shl_ext[W-1:0];
        alu_c   = (shamt == '0) ? cin : shl_ext[W];
      end
      OP_SHR: begin
        alu_res = shr_ext[W:1];
        alu_c   = (shamt == '0) ? cin : shr_ext[0];
      end
      OP_ASR: begin
        alu_res = asr_ext[W:1];
        alu_c   = (shamt == '0) ? cin : asr_ext[0];
      end
      default: is_nop = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    res_d   = res_q;
    hi_d    = hi_q;
    apsr_d  = apsr_q;
    vld_d   = 1'b0;
    mul_sum = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (op_i == OP_MUL) begin
            mcand_d = a_i;
            acc_d   = {{W{1'b0}}, b_i};
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            res_d  = alu_res;
            hi_d   = '0;
            apsr_d = is_nop ? psr_i : {alu_res[W-1], alu_res == '0, alu_c, alu_v};
            vld_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        // Multiplier sits in the low half and drains out as the product shifts in.
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d   = {mul_sum, acc_q[W-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SHAMT_WIDTH'(W - 1)) begin
          res_d   = acc_d[W-1:0];
          hi_d    = acc_d[2*W-1:W];
          apsr_d  = {acc_d[W-1], acc_d[W-1:0] == '0, |acc_d[2*W-1:W], 1'b0};
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      apsr_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      apsr_q  <= apsr_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = vld_q;
  assign result_o    = res_q;
  assign result_hi_o = hi_q;
  assign apsr_o      = apsr_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the MCU's combinational ALU. Covers the existing add/sub/carry and NAND/NOR/XOR/XNOR set, and adds shifts and an iterative unsigned multiply. Result and flags are registered, with a valid/ready input handshake and a valid output pulse. Sits between the decode/register-file read stage and write-back. Single-cycle ops sustain one result per clock; MUL stalls the issue stage.

## Interface
- DATA_WIDTH, 8, operand/result width; power of two, ≥ 4
- SHAMT_WIDTH, log2(DATA_WIDTH), width of shift-amount field taken from b_i
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid_i  in  1  operation presented
- in_ready_o  out  1  block can accept; transfer when in_valid_i & in_ready_o at rising edge
- op_i  in  4  operation code
- a_i  in  DATA_WIDTH  first operand
- b_i  in  DATA_WIDTH  second operand / shift amount
- psr_i  in  4  incoming flags {N,Z,C,V}; C used as carry-in
- out_valid_o  out  1  one-cycle pulse, result/flags valid
- result_o  out  DATA_WIDTH  result (MUL: low half)
- result_hi_o  out  DATA_WIDTH  MUL high half; 0 for all other ops
- apsr_o  out  4  flags {N,Z,C,V}

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 ADDC
  - 4 SUBC
  - 5 NAND
  - 6 NOR
  - 7 XOR
  - 8 XNOR
  - 9 SHL
  - A SHR
  - B ASR
  - C MUL
  - D–F treated as NOP
- NOP behaviour: result = a_i; apsr_o = psr_i.
- ADD / ADDC: a + b (+ C_in for ADDC), computed at DATA_WIDTH+1 bits; C = bit DATA_WIDTH.
- SUB: a + ~b + 1.
- SUBC: a + ~b + C_in.
- Carry convention for SUB/SUBC: C = 1 means no borrow.
- V (add/sub only): set on signed overflow, i.e. operand signs as seen by the adder agree and the result sign differs.
- Logic ops: C = C_in, V = 0.
- Shifts:
  - Amount is b_i[SHAMT_WIDTH-1:0]; upper bits of b_i are ignored.
  - C = last bit shifted out; amount 0 gives C = C_in.
  - V = 0.
  - ASR replicates the MSB.
- MUL: unsigned, 2·DATA_WIDTH-bit product via shift-add, one bit per cycle.
  - result_o = low half; result_hi_o = high half.
  - C = |high half; V = 0.
- All ops: N = result_o MSB; Z = (result_o == 0).
- FSM states and transitions:
  - IDLE, in_ready_o = 1:
    - Accept of a non-MUL op: register result/flags, pulse out_valid_o, remain in IDLE.
    - Accept of MUL: latch operands, clear accumulator, counter = 0, go to MUL.
  - MUL, in_ready_o = 0:
    - Each cycle: if multiplier LSB is set, add multiplicand to the accumulator high half; then shift right.
    - counter increments each cycle.
    - When counter reaches DATA_WIDTH-1: register outputs, pulse out_valid_o, return to IDLE.
- result_o, result_hi_o and apsr_o hold their last value until the next completion.
- No output back-pressure: the consumer must take the result in the out_valid_o cycle.

## Timing
- Reset values:
  - in_ready_o = 1, out_valid_o = 0.
  - result_o = 0, result_hi_o = 0, apsr_o = 0.
  - FSM = IDLE, counter = 0.
- Non-MUL latency: accepted at edge k → outputs and out_valid_o high in cycle k..k+1. Back-to-back accepts give consecutive pulses.
- MUL latency:
  - Accepted at edge k; iterations on edges k+1..k+DATA_WIDTH.
  - out_valid_o is high in the cycle after edge k+DATA_WIDTH.
  - in_ready_o is low from edge k until edge k+DATA_WIDTH.
  - The earliest next accept is edge k+DATA_WIDTH+1.
- in_valid_i while in_ready_o = 0 is ignored; the issuer must hold its request.
- Operands and psr_i are sampled only at accept; later changes do not affect an in-flight MUL.
- Reset asserted mid-MUL: immediate (asynchronous) return to reset values. No out_valid_o pulse is produced for the aborted op.
- out_valid_o is never high for two cycles for a single op.

## Test plan
- ADD a=FF, b=01, psr C=0 (W=8) → result 00, apsr N0 Z1 C1 V0; out_valid_o one cycle after accept.
- SUBC a=AA, b=AA, C=0 → result FF, N1 Z0 C0 V0. Then SUB AE−AE → result 00, Z1 C1.
- ADD 7F+01 → 80 with N1 V1 C0. XNOR A7,7A → 22. NAND FF,FF → 00 with Z1.
- ASR a=80, b=03 → F0, C0. SHL a=81, b=01 → 02, C1. SHR with amount 0 → a unchanged, C = psr C.
- MUL FF×FF → result 01, hi FE, C1.
  - in_ready_o low for 8 cycles; out_valid_o exactly 8 cycles after accept.
  - in_valid_i held during the stall is accepted only at edge k+9.
- Reset pulse mid-MUL (cycle 4) → all outputs 0, in_ready_o 1, no out_valid_o.
  - A following ADD 01+01 → 02 after 1 cycle.
